// File: rtl/conv_encoder_k3_if.sv
// Handshake bundle for the K=3 convolutional encoder.
// Upstream side: i_valid/o_ready/i_data carry one information word per frame.
// Downstream side: o_valid/i_ready/o_data/o_last carry one code symbol per beat.
// Both sides use strict valid/ready semantics: a transfer happens on a rising
// clock edge where valid and ready are both high; once valid is raised, the
// payload must stay stable until that edge.
interface conv_encoder_k3_if #(
  parameter int DATA_W = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              i_ready;
  logic [1:0]        o_data;
  logic              o_valid;
  logic              o_last;
  logic              o_busy;
  logic [1:0]        dbg_state;

  // Encoder side.
  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_data, o_valid, o_last, o_busy, dbg_state
  );

  // Word source and symbol sink side.
  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_busy, dbg_state
  );
endinterface

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (default generators 7,5 octal).
// One DATA_W-bit word per frame is shifted out MSB first, one 2-bit symbol
// {g0,g1} per bit, optionally followed by two zero-input tail symbols that
// return the encoder to state 00. Every frame starts from state 00.
module conv_encoder_k3 #(
  parameter int         DATA_W  = 8,
  parameter int         TAIL_EN = 1,
  parameter logic [2:0] G0      = 3'b111,
  parameter logic [2:0] G1      = 3'b101
) (
  input  logic           i_clk,
  input  logic           i_rst,
  conv_encoder_k3_if.slave bus
);

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W);
  localparam logic [CW-1:0] PEN_CNT  = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] sreg;      // remaining data bits, next one at the MSB
  logic              s1;        // most recent input bit
  logic              s2;        // input bit before s1
  logic [CW-1:0]     cnt;       // symbols emitted in the current phase
  logic [1:0]        data_q;
  logic              valid_q;
  logic              last_q;
  logic              ready;
  logic              accept;
  logic              advance;

  // Code symbol for input u with encoder state {a,b}.
  function automatic logic [1:0] enc(input logic u, input logic a, input logic b);
    enc = {^(G0 & {u, a, b}), ^(G1 & {u, a, b})};
  endfunction

  // Ready when idle, or when the final symbol leaves this cycle so the next
  // word can be taken on the same edge without a bubble.
  always_comb begin
    ready   = !i_rst && ((state == IDLE) || (valid_q && last_q && bus.i_ready));
    accept  = bus.i_valid && ready;
    advance = valid_q && bus.i_ready;
  end

  // Frame sequencing, symbol generation and encoder state update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      sreg    <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      data_q  <= 2'b00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (accept) begin
      // New frame: first symbol from the MSB with state forced to 00.
      sreg    <= bus.i_data << 1;
      data_q  <= enc(bus.i_data[DATA_W-1], 1'b0, 1'b0);
      s1      <= bus.i_data[DATA_W-1];
      s2      <= 1'b0;
      cnt     <= CW'(1);
      valid_q <= 1'b1;
      last_q  <= 1'b0;
      state   <= SHIFT;
    end else if (advance) begin
      if (last_q) begin
        // Final symbol consumed with no follow-on word.
        state   <= IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= 2'b00;
        s1      <= 1'b0;
        s2      <= 1'b0;
        cnt     <= '0;
      end else if ((state == SHIFT) && (cnt != LAST_CNT)) begin
        // Next data bit.
        data_q <= enc(sreg[DATA_W-1], s1, s2);
        s1     <= sreg[DATA_W-1];
        s2     <= s1;
        sreg   <= sreg << 1;
        cnt    <= cnt + 1'b1;
        last_q <= (TAIL_EN == 0) && (cnt == PEN_CNT);
      end else if (state == SHIFT) begin
        // Data exhausted and not last, so the tail is enabled: first flush bit.
        state  <= TAIL;
        data_q <= enc(1'b0, s1, s2);
        s1     <= 1'b0;
        s2     <= s1;
        cnt    <= CW'(1);
        last_q <= 1'b0;
      end else begin
        // Second flush bit ends the frame.
        data_q <= enc(1'b0, s1, s2);
        s1     <= 1'b0;
        s2     <= s1;
        cnt    <= CW'(2);
        last_q <= 1'b1;
      end
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_data    = data_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_last    = last_q;
  assign bus.o_busy    = (state != IDLE);
  assign bus.dbg_state = state;

endmodule

// File: doc/conv_encoder_k3.md
Name: conv_encoder_k3

Overview:
Rate-1/2, constraint-length-3 convolutional encoder (generators G0=111, G1=101, i.e. 7,5 octal). It is the transmit-side counterpart of the Viterbi decoding block. It accepts one DATA_W-bit word per frame over a valid/ready handshake and serializes it MSB-first. It emits one 2-bit code symbol per input bit, optionally followed by zero-flush tail symbols. Each frame starts from encoder state 00, which matches the decoder's per-frame reset.

Parameters:
DATA_W, 8, information bits per frame (legal range 2..32)
TAIL_EN, 1, 1 = append 2 tail symbols (input 0) to flush the encoder to state 00; 0 = no tail
G0, 3'b111, generator for o_data[1]; bit2 taps the current input, bit1 taps s1, bit0 taps s2
G1, 3'b101, generator for o_data[0]; same tap ordering as G0

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_valid  in  1  upstream word valid
o_ready  out  1  encoder can accept a word this cycle
i_data  in  DATA_W  information word, transmitted MSB first
i_ready  in  1  downstream accepts the current symbol
o_data  out  2  code symbol {g0, g1}
o_valid  out  1  o_data is valid
o_last  out  1  final symbol of the frame (qualified by o_valid)
o_busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (async, i_rst=1): state=IDLE, o_data=2'b00, o_valid=0, o_last=0, o_busy=0, o_ready=0 while i_rst is high. Shift register, encoder state {s1,s2} and bit counter are cleared.
- Encoder math, for input bit u and state {s1,s2}:
  - g0 = ^(G0 & {u,s1,s2}); g1 = ^(G1 & {u,s1,s2}).
  - Next state = {u, s1}.
- o_ready = (state==IDLE) | (o_valid & o_last & i_ready). This is combinational and allows zero-bubble back-to-back frames.
- Accept condition: i_valid & o_ready at a rising edge. When i_valid=1 but o_ready=0, i_data is ignored and upstream must hold it.
- On accept edge:
  - Latch i_data into the shift register.
  - Compute the first symbol using u = i_data[DATA_W-1] and state 00.
  - Set o_valid<=1, state {s1,s2}<={u,0}, counter<=1, FSM->SHIFT.
  - Latency: 1 cycle from accept to first symbol.
- Symbol advance: at each edge with o_valid & i_ready, the next symbol is registered.
  - When o_valid & !i_ready, o_data, o_last and all internal state hold exactly (stall).
- FSM:
  - IDLE -> SHIFT on accept.
  - SHIFT emits DATA_W symbols. If TAIL_EN=1, it goes to TAIL after the DATA_W-th symbol is consumed; TAIL emits 2 symbols with u=0.
  - After the last symbol is consumed: go back to SHIFT if a new word is accepted on the same edge, otherwise go to IDLE with o_valid<=0.
- Frame length: DATA_W + 2*TAIL_EN symbols. o_last=1 only on the final one.
- Encoder state after a TAIL_EN=1 frame is always 00. Every new frame forces state 00 regardless of TAIL_EN.
- Reset asserted mid-frame: the frame is dropped immediately, with no partial flush; outputs take reset values.
- o_busy=1 from the accept edge until the edge on which the final symbol is consumed without a new accept.

Test Plan:
1. DATA_W=8, TAIL_EN=0, i_ready=1, word 8'b11011010 -> symbols 11,01,01,00,01,01,00,10. First symbol appears 1 cycle after accept; o_last on the 8th; o_ready=1 the cycle after.
2. TAIL_EN=0, word 8'b10101010 -> 11,10,00,10,00,10,00,10. With TAIL_EN=1, the same word adds tail 11,00, giving 10 symbols with o_last on the 10th.
3. TAIL_EN=1, word 8'b00000001 -> 00 x7, 11, then tail 10,11. Also: i_valid pulsed while o_busy=1 mid-frame is ignored, and the sequence is unchanged.
4. Backpressure: word 8'b11011010, hold i_ready=0 for 3 cycles while the 4th symbol is presented -> o_data stays 00 with o_valid=1 for all 3 cycles. The remaining symbols follow in order with no loss or duplication.
5. Back-to-back: present 8'b11011010 then 8'b10101010 with i_valid held high (TAIL_EN=0) -> o_ready=1 on the cycle the first frame's o_last symbol is consumed. Output is 16 contiguous symbols; the second frame restarts from state 00, so its first symbol is 11.
6. Reset mid-frame: assert i_rst asynchronously after the 3rd symbol -> o_valid, o_last, o_busy and o_data go to 0 immediately without waiting for a clock edge. After release, 8'b00000001 encodes exactly as in scenario 3.
